// File: rtl/pwm_duty_sequencer_if.sv
// Duty request handshake and PWM status bundle for pwm_duty_sequencer.
// The master side drives the timebase, enable and duty requests; the slave side is the sequencer.
interface pwm_duty_sequencer_if #(
  parameter int unsigned CW         = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  logic          enable;
  logic [CW-1:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;
  logic          pwm_out;
  logic [CW-1:0] duty_active;
  logic [LW-1:0] fifo_level;
  logic          period_tick;
  logic          err_clip;

  modport master (
    output count, enable, duty_in, duty_valid,
    input  duty_ready, pwm_out, duty_active, fifo_level, period_tick, err_clip
  );

  modport slave (
    input  count, enable, duty_in, duty_valid,
    output duty_ready, pwm_out, duty_active, fifo_level, period_tick, err_clip
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Buffers duty requests and applies them only at PWM period boundaries; gates output per whole period.
// Optional soft-start ramping is compiled in with `define PWM_SOFTSTART_EN.
module pwm_duty_sequencer #(
  parameter int unsigned CW         = 8,
  parameter int unsigned PERIOD_MAX = 100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 5
) (
  input logic                 clk,
  input logic                 rst,
  pwm_duty_sequencer_if.slave bus
);
  localparam int unsigned   AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] TERM    = CW'(PERIOD_MAX);
  localparam logic [CW-1:0] FULL_ON = CW'(PERIOD_MAX + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two of at least 2");
  end
  if (RAMP_STEP == 0 || PERIOD_MAX + 1 >= 2 ** CW) begin : g_param_check
    $error("RAMP_STEP must be nonzero and PERIOD_MAX+1 must fit in CW bits");
  end

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t        state, state_nxt;
  logic          run_out;
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, boundary, push, pop, duty_ready;
  logic [CW-1:0] duty_clip, duty_active;
  logic          pwm_out, period_tick, err_clip;

  assign boundary   = (bus.count == TERM);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign duty_ready = !full && rst;
  assign push       = bus.duty_valid && duty_ready;
  assign duty_clip  = (bus.duty_in > FULL_ON) ? FULL_ON : bus.duty_in;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: leaving RUN waits for the boundary so a started period always completes
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.enable) state_nxt = ARM;
      ARM: begin
        if (!bus.enable)   state_nxt = IDLE;
        else if (boundary) state_nxt = RUN;
      end
      RUN:  if (boundary && !bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    run_out = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= duty_clip;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      err_clip    <= 1'b0;
      period_tick <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && (bus.duty_in > FULL_ON)) err_clip <= 1'b1;
      period_tick <= boundary;
      pwm_out     <= run_out && (bus.count < duty_active);
    end
  end

`ifdef PWM_SOFTSTART_EN
  localparam logic [CW-1:0] STEP = CW'(RAMP_STEP);

  logic [CW-1:0] target, ramp_nxt;
  logic          leave_idle;

  assign leave_idle = (state == IDLE) && (state_nxt == ARM);
  // The queue is held until the ramp has landed on the current target
  assign pop = boundary && !empty && (duty_active == target);

  always_comb begin
    ramp_nxt = duty_active;
    if (target > duty_active)
      ramp_nxt = ((target - duty_active) > STEP) ? duty_active + STEP : target;
    else if (target < duty_active)
      ramp_nxt = ((duty_active - target) > STEP) ? duty_active - STEP : target;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      target      <= '0;
      duty_active <= '0;
    end else begin
      if (pop) target <= mem[rd_ptr];
      if (leave_idle)    duty_active <= '0;
      else if (boundary) duty_active <= ramp_nxt;
    end
  end
`else
  assign pop = boundary && !empty;

  always_ff @(posedge clk) begin
    if (!rst)     duty_active <= '0;
    else if (pop) duty_active <= mem[rd_ptr];
  end
`endif

  assign bus.duty_ready  = duty_ready;
  assign bus.pwm_out     = pwm_out;
  assign bus.duty_active = duty_active;
  assign bus.fifo_level  = level;
  assign bus.period_tick = period_tick;
  assign bus.err_clip    = err_clip;
endmodule
